// File: rtl/sag4fun32c_pkg.sv
// Shared constants, word type and helpers for the sheep-and-goats permutation unit.
package sag4fun_pkg;

  localparam int SAG_XLEN = 32;
  localparam int SAG_LOG2 = 5;

  typedef logic [SAG_XLEN-1:0] sag_word_t;

  function automatic sag_word_t bit_reverse(input sag_word_t w);
    sag_word_t r;
    r = '0;
    for (int i = 0; i < SAG_XLEN; i++) begin
      r[i] = w[SAG_XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sag4fun32c_if.sv
// Operand/result bus of the SAG unit. Flow control: a result is presented with
// out_valid high for exactly one cycle, one cycle after in_valid; there is no ready.
interface sag4fun32c_if;
  import sag4fun_pkg::*;

  logic      in_valid;
  logic      ctrl_inv;
  logic      ctrl_msk;
  sag_word_t in_data;
  sag_word_t in_mask;
  logic      out_valid;
  sag_word_t out_data;

  modport master (
    output in_valid, ctrl_inv, ctrl_msk, in_data, in_mask,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, ctrl_inv, ctrl_msk, in_data, in_mask,
    output out_valid, out_data
  );

endinterface

// File: rtl/sag4fun32c_core.sv
// Combinational SAG / inverse-SAG datapath, routed by prefix popcounts of the mask.
module sag4fun32c_core
  import sag4fun_pkg::*;
(
  input  sag_word_t data,
  input  sag_word_t mask,
  input  logic      inv,
  input  logic      msk,
  output sag_word_t result
);

  logic [SAG_LOG2-1:0] sheep_pos [SAG_XLEN];
  logic [SAG_LOG2-1:0] goat_pos  [SAG_XLEN];
  sag_word_t           fwd_word;
  sag_word_t           inv_word;

  always_comb begin
    logic [SAG_LOG2:0] ones_below;
    logic [SAG_LOG2:0] zeros_below;
    ones_below  = '0;
    zeros_below = '0;
    fwd_word    = '0;
    inv_word    = '0;
    for (int i = 0; i < SAG_XLEN; i++) begin
      zeros_below  = (SAG_LOG2+1)'(i) - ones_below;
      sheep_pos[i] = ones_below[SAG_LOG2-1:0];
      // Goats fill from bit 31 downward: 31 - z is the 5-bit complement of z.
      goat_pos[i]  = ~zeros_below[SAG_LOG2-1:0];
      ones_below   = ones_below + {{SAG_LOG2{1'b0}}, mask[i]};
    end
    for (int i = 0; i < SAG_XLEN; i++) begin
      if (mask[i]) begin
        fwd_word[sheep_pos[i]] = data[i];
        inv_word[i]            = data[sheep_pos[i]];
      end else begin
        fwd_word[goat_pos[i]]  = data[i] & ~msk;
        inv_word[i]            = data[goat_pos[i]] & ~msk;
      end
    end
    result = inv ? inv_word : fwd_word;
  end

endmodule

// File: rtl/sag4fun32c.sv
// SAG functional unit: one-cycle latency, registered result, no backpressure.
module sag4fun32c
  import sag4fun_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  sag4fun32c_if.slave       bus
);

  sag_word_t core_result;

  sag4fun32c_core u_core (
    .data   (bus.in_data),
    .mask   (bus.in_mask),
    .inv    (bus.ctrl_inv),
    .msk    (bus.ctrl_msk),
    .result (core_result)
  );

  // out_data holds the last result while idle; only out_valid returns to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_data <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_sag4fun32c.sv
// Bench for sag4fun32c: directed vectors, random model comparison and round-trip checks.
module tb_sag4fun32c;
  import sag4fun_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  int   n_issued;
  int   n_seen;
  logic [31:0] exp_q[$];

  sag4fun32c_if bus();

  sag4fun32c dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_sag(input logic [31:0] d, input logic [31:0] m,
                                          input logic inv, input logic msk);
    logic [31:0] r;
    int lo;
    int hi;
    r  = '0;
    lo = 0;
    hi = 31;
    for (int i = 0; i < 32; i++) begin
      if (!inv) begin
        if (m[i]) begin r[lo] = d[i]; lo++; end
        else      begin r[hi] = msk ? 1'b0 : d[i]; hi--; end
      end else begin
        if (m[i]) begin r[i] = d[lo]; lo++; end
        else      begin r[i] = msk ? 1'b0 : d[hi]; hi--; end
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_raw(input logic [31:0] d, input logic [31:0] m,
                           input logic inv, input logic msk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mask  = m;
    bus.ctrl_inv = inv;
    bus.ctrl_msk = msk;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] m,
                       input logic inv, input logic msk, input logic [31:0] exp);
    drive_raw(d, m, inv, msk);
    exp_q.push_back(exp);
    n_issued++;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_mask  = $urandom;
    bus.ctrl_inv = 1'($urandom_range(0, 1));
    bus.ctrl_msk = 1'($urandom_range(0, 1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%08h expected no output at %0t", bus.out_data, $time);
      end else begin
        check("result", bus.out_data, exp_q.pop_front());
        n_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] d;
    logic [31:0] m;
    logic        inv;
    logic        msk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] x;
    logic [31:0] m;
    logic [31:0] f;
    logic        rmsk;
    checks   = 0;
    errors   = 0;
    n_issued = 0;
    n_seen   = 0;

    vecs[0] = '{32'hB3389E39, 32'h690AEA75, 1'b0, 1'b0, 32'h4CCB5A6D};
    vecs[1] = '{32'hB3389E39, 32'h690AEA75, 1'b0, 1'b1, 32'h00005A6D};
    vecs[2] = '{32'h4CCB5A6D, 32'h690AEA75, 1'b1, 1'b0, 32'hB3389E39};
    vecs[3] = '{32'h4CCB5A6D, 32'h690AEA75, 1'b1, 1'b1, 32'h21088A31};
    vecs[4] = '{32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h12345678};
    vecs[5] = '{32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h12345678};
    vecs[6] = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 32'h80000000};
    vecs[7] = '{32'h00000001, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    vecs[8] = '{32'h00000001, 32'h00000000, 1'b1, 1'b0, 32'h80000000};

    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mask  = '0;
    bus.ctrl_inv = 1'b0;
    bus.ctrl_msk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors, one per cycle with an idle gap between each.
    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].m, vecs[i].inv, vecs[i].msk, vecs[i].exp);
      idle();
    end

    // Back-to-back burst, then out_valid must drop one cycle after in_valid.
    drive(32'hB3389E39, 32'h690AEA75, 1'b0, 1'b0, 32'h4CCB5A6D);
    drive(32'h4CCB5A6D, 32'h690AEA75, 1'b1, 1'b1, 32'h21088A31);
    drive(32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h12345678);
    idle();
    @(negedge clk);
    check("burst_last_valid", {31'b0, bus.out_valid}, 32'd1);
    @(negedge clk);
    check("valid_drop", {31'b0, bus.out_valid}, 32'd0);
    check("data_hold", bus.out_data, 32'h12345678);

    // Asynchronous reset while a result is being presented.
    drive_raw(32'hB3389E39, 32'h690AEA75, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
    check("pre_reset_data", bus.out_data, 32'h4CCB5A6D);
    bus.in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_reset_data", bus.out_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    @(negedge clk);
    check("post_reset_data", bus.out_data, 32'd0);

    // Random model comparison plus inverse(forward(x, m), m) == x.
    for (int n = 0; n < 5000; n++) begin
      x = $urandom;
      case (n % 8)
        0:       m = 32'h0;
        1:       m = 32'hFFFFFFFF;
        default: m = $urandom;
      endcase
      rmsk = 1'($urandom_range(0, 1));
      f = ref_sag(x, m, 1'b0, rmsk);
      if (m == 32'h0 && !rmsk) check("model_bitrev", f, bit_reverse(x));
      drive(x, m, 1'b0, rmsk, f);
      drive(x, m, 1'b1, rmsk, ref_sag(x, m, 1'b1, rmsk));
      drive(ref_sag(x, m, 1'b0, 1'b0), m, 1'b1, 1'b0, x);
    end
    idle();
    repeat (3) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_seen), 32'(n_issued));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
